// File: rtl/cu_issue_scheduler.sv
// In-order issue stage for the vector unit. It accepts one decoded op into a
// single-entry hold register. A per-register scoreboard checks RAW and WAW
// hazards. ALU ops go round-robin to NUM_ALUS ALUs, and loads/stores go to the
// single memory unit. Units report completion with 1-cycle done pulses.
module cu_issue_scheduler #(
  parameter int NUM_REGS      = 4,
  parameter int MVL           = 16,
  parameter int ADDRESS_WIDTH = 10,
  parameter int NUM_ALUS      = 2,
  localparam int REG_W        = (NUM_REGS <= 1) ? 1 : $clog2(NUM_REGS),
  localparam int VL_W         = (MVL <= 1) ? 1 : $clog2(MVL)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     ins_valid_i,
  output logic                     ins_ready_o,
  input  logic                     add_i,
  input  logic                     sub_i,
  input  logic                     load_i,
  input  logic                     store_i,
  input  logic [REG_W-1:0]         src1_i,
  input  logic [REG_W-1:0]         src2_i,
  input  logic [REG_W-1:0]         dst_i,
  input  logic [ADDRESS_WIDTH-1:0] addr_i,
  input  logic [VL_W-1:0]          vlen_i,
  output logic [NUM_ALUS-1:0]      alu_valid_o,
  output logic                     mem_load_o,
  output logic                     mem_store_o,
  output logic                     disp_sub_o,
  output logic [REG_W-1:0]         disp_src1_o,
  output logic [REG_W-1:0]         disp_src2_o,
  output logic [REG_W-1:0]         disp_dst_o,
  output logic [ADDRESS_WIDTH-1:0] disp_addr_o,
  output logic [VL_W-1:0]          disp_vlen_o,
  input  logic [NUM_ALUS-1:0]      alu_done_i,
  input  logic                     mem_done_i,
  output logic                     err_o,
  output logic                     idle_o
);

  localparam int ALU_W = (NUM_ALUS <= 1) ? 1 : $clog2(NUM_ALUS);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_HOLD  = 1'b1
  } state_t;

  // ALU index arithmetic that wraps from NUM_ALUS-1 back to 0. The offset
  // is always below NUM_ALUS, so one conditional subtract is enough.
  function automatic logic [ALU_W-1:0] alu_wrap(input logic [ALU_W-1:0] base,
                                                input logic [ALU_W:0]   off);
    logic [ALU_W+1:0] sum;
    sum = {2'b00, base} + {1'b0, off};
    if (sum >= (ALU_W+2)'(NUM_ALUS)) sum = sum - (ALU_W+2)'(NUM_ALUS);
    return sum[ALU_W-1:0];
  endfunction

  state_t                     state;
  logic                       hold_v;

  logic                       hold_add_p0;
  logic                       hold_sub_p0;
  logic                       hold_load_p0;
  logic                       hold_store_p0;
  logic [REG_W-1:0]           hold_src1_p0;
  logic [REG_W-1:0]           hold_src2_p0;
  logic [REG_W-1:0]           hold_dst_p0;
  logic [ADDRESS_WIDTH-1:0]   hold_addr_p0;
  logic [VL_W-1:0]            hold_vlen_p0;

  logic [NUM_ALUS-1:0]        alu_busy;
  logic [REG_W-1:0]           alu_dst [NUM_ALUS];
  logic                       mem_busy;
  logic                       mem_is_load;
  logic [REG_W-1:0]           mem_dst;
  logic [ALU_W-1:0]           rr_ptr;
  logic [NUM_REGS-1:0]        sb;
  logic [NUM_REGS-1:0]        sb_next;

  logic                       op_legal;
  logic                       alu_found;
  logic [ALU_W-1:0]           alu_sel;
  logic                       alu_ok;
  logic                       ld_ok;
  logic                       st_ok;
  logic                       alu_iss;
  logic                       ld_iss;
  logic                       st_iss;
  logic                       issue_go;
  logic                       drop;
  logic                       issue_fire;
  logic                       accept;

  assign hold_v = (state == S_HOLD);

  // Pick the first free ALU, scanning upward from the round-robin pointer.
  always_comb begin
    alu_found = 1'b0;
    alu_sel   = '0;
    for (int i = 0; i < NUM_ALUS; i++) begin
      logic [ALU_W-1:0] cand;
      cand = alu_wrap(rr_ptr, (ALU_W+1)'(i));
      if (!alu_found && !alu_busy[cand]) begin
        alu_found = 1'b1;
        alu_sel   = cand;
      end
    end
  end

  // The issue check looks only at the hold register and registered unit and
  // scoreboard state. Done pulses are not bypassed into it.
  always_comb begin
    op_legal   = $onehot({hold_add_p0, hold_sub_p0, hold_load_p0, hold_store_p0});
    alu_ok     = (hold_add_p0 | hold_sub_p0) & alu_found &
                 !sb[hold_src1_p0] & !sb[hold_src2_p0] & !sb[hold_dst_p0];
    ld_ok      = hold_load_p0  & !mem_busy & !sb[hold_dst_p0];
    st_ok      = hold_store_p0 & !mem_busy & !sb[hold_src1_p0];
    alu_iss    = hold_v & op_legal & alu_ok;
    ld_iss     = hold_v & op_legal & ld_ok;
    st_iss     = hold_v & op_legal & st_ok;
    issue_go   = alu_iss | ld_iss | st_iss;
    drop       = hold_v & !op_legal;
    issue_fire = issue_go | drop;
  end

  assign ins_ready_o = !hold_v | issue_fire;
  assign accept      = ins_valid_i & ins_ready_o;
  assign idle_o      = !hold_v & !(|alu_busy) & !mem_busy & !(|sb);

  // Scoreboard next state. Done pulses clear bits first, then a new issue
  // sets its destination bit, so a set wins on the same edge.
  always_comb begin
    sb_next = sb;
    for (int k = 0; k < NUM_ALUS; k++) begin
      if (alu_done_i[k] && alu_busy[k]) sb_next[alu_dst[k]] = 1'b0;
    end
    if (mem_done_i && mem_busy && mem_is_load) sb_next[mem_dst] = 1'b0;
    if (alu_iss || ld_iss) sb_next[hold_dst_p0] = 1'b1;
  end

  // Hold-register FSM and the registered dispatch outputs (stage p0 -> p1).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= S_EMPTY;
      alu_valid_o <= '0;
      mem_load_o  <= 1'b0;
      mem_store_o <= 1'b0;
      err_o       <= 1'b0;
      disp_sub_o  <= 1'b0;
      disp_src1_o <= '0;
      disp_src2_o <= '0;
      disp_dst_o  <= '0;
      disp_addr_o <= '0;
      disp_vlen_o <= '0;
    end else begin
      alu_valid_o <= alu_iss ? ((NUM_ALUS)'(1) << alu_sel) : '0;
      mem_load_o  <= ld_iss;
      mem_store_o <= st_iss;
      err_o       <= drop;
      if (issue_go) begin
        disp_sub_o  <= hold_sub_p0;
        disp_src1_o <= hold_src1_p0;
        disp_src2_o <= hold_src2_p0;
        disp_dst_o  <= hold_dst_p0;
        disp_addr_o <= hold_addr_p0;
        disp_vlen_o <= hold_vlen_p0;
      end
      case (state)
        S_EMPTY: if (accept) state <= S_HOLD;
        S_HOLD:  if (issue_fire && !accept) state <= S_EMPTY;
        default: state <= S_EMPTY;
      endcase
    end
  end

  // Unit busy flags, the round-robin pointer and the scoreboard.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      alu_busy    <= '0;
      mem_busy    <= 1'b0;
      mem_is_load <= 1'b0;
      rr_ptr      <= '0;
      sb          <= '0;
    end else begin
      sb <= sb_next;
      for (int k = 0; k < NUM_ALUS; k++) begin
        if (alu_done_i[k]) alu_busy[k] <= 1'b0;
      end
      if (alu_iss) begin
        alu_busy[alu_sel] <= 1'b1;
        rr_ptr            <= alu_wrap(alu_sel, (ALU_W+1)'(1));
      end
      if (mem_done_i) mem_busy <= 1'b0;
      if (ld_iss || st_iss) begin
        mem_busy    <= 1'b1;
        mem_is_load <= ld_iss;
      end
    end
  end

  // Held operation fields and the destination recorded for each busy unit.
  // These are qualified by hold_v or the busy flags, so they need no reset.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      hold_add_p0   <= add_i;
      hold_sub_p0   <= sub_i;
      hold_load_p0  <= load_i;
      hold_store_p0 <= store_i;
      hold_src1_p0  <= src1_i;
      hold_src2_p0  <= src2_i;
      hold_dst_p0   <= dst_i;
      hold_addr_p0  <= addr_i;
      hold_vlen_p0  <= vlen_i;
    end
    if (alu_iss) alu_dst[alu_sel] <= hold_dst_p0;
    if (ld_iss)  mem_dst          <= hold_dst_p0;
  end

endmodule

// File: tb/tb_cu_issue_scheduler.sv
// Testbench for cu_issue_scheduler. It runs directed scenarios and then
// randomized traffic. Expected values come from an in-flight-op reference
// model. In that model a register counts as pending while an in-flight ALU op
// or load writes it.
module tb_cu_issue_scheduler;

  localparam int NR = 4;
  localparam int MV = 16;
  localparam int AW = 10;
  localparam int NA = 2;
  localparam int RW = 2;
  localparam int VW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_ni;
  logic          ins_valid_i;
  logic          ins_ready_o;
  logic          add_i, sub_i, load_i, store_i;
  logic [RW-1:0] src1_i, src2_i, dst_i;
  logic [AW-1:0] addr_i;
  logic [VW-1:0] vlen_i;
  logic [NA-1:0] alu_valid_o;
  logic          mem_load_o, mem_store_o, disp_sub_o;
  logic [RW-1:0] disp_src1_o, disp_src2_o, disp_dst_o;
  logic [AW-1:0] disp_addr_o;
  logic [VW-1:0] disp_vlen_o;
  logic [NA-1:0] alu_done_i;
  logic          mem_done_i;
  logic          err_o, idle_o;

  cu_issue_scheduler #(
    .NUM_REGS(NR), .MVL(MV), .ADDRESS_WIDTH(AW), .NUM_ALUS(NA)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .ins_valid_i(ins_valid_i), .ins_ready_o(ins_ready_o),
    .add_i(add_i), .sub_i(sub_i), .load_i(load_i), .store_i(store_i),
    .src1_i(src1_i), .src2_i(src2_i), .dst_i(dst_i),
    .addr_i(addr_i), .vlen_i(vlen_i),
    .alu_valid_o(alu_valid_o), .mem_load_o(mem_load_o), .mem_store_o(mem_store_o),
    .disp_sub_o(disp_sub_o), .disp_src1_o(disp_src1_o), .disp_src2_o(disp_src2_o),
    .disp_dst_o(disp_dst_o), .disp_addr_o(disp_addr_o), .disp_vlen_o(disp_vlen_o),
    .alu_done_i(alu_done_i), .mem_done_i(mem_done_i),
    .err_o(err_o), .idle_o(idle_o)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state: the held op (if any) and the op in flight on each unit.
  bit            m_held;
  int            h_op;            // 0 add, 1 sub, 2 load, 3 store, 4 illegal
  logic [RW-1:0] h_s1, h_s2, h_d;
  logic [AW-1:0] h_addr;
  logic [VW-1:0] h_vl;
  bit            m_alu_busy [NA];
  logic [RW-1:0] m_alu_dst  [NA];
  bit            m_mem_busy, m_mem_ld;
  logic [RW-1:0] m_mem_dst;
  int            m_rr;
  bit            m_accept;

  logic [NA-1:0] e_alu_valid;
  logic          e_ml, e_ms, e_err, e_sub;
  logic [RW-1:0] e_s1, e_s2, e_d;
  logic [AW-1:0] e_addr;
  logic [VW-1:0] e_vl;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int classify(input logic a, input logic s, input logic l, input logic st);
    int n;
    n = int'(a) + int'(s) + int'(l) + int'(st);
    if (n != 1) return 4;
    if (a) return 0;
    if (s) return 1;
    if (l) return 2;
    return 3;
  endfunction

  function automatic bit pending(input logic [RW-1:0] r);
    for (int k = 0; k < NA; k++)
      if (m_alu_busy[k] && m_alu_dst[k] == r) return 1'b1;
    if (m_mem_busy && m_mem_ld && m_mem_dst == r) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_held = 0; h_op = 0; m_rr = 0; m_mem_busy = 0; m_mem_ld = 0; m_accept = 0;
    for (int k = 0; k < NA; k++) begin m_alu_busy[k] = 0; m_alu_dst[k] = '0; end
    m_mem_dst = '0;
    e_alu_valid = '0; e_ml = 0; e_ms = 0; e_err = 0; e_sub = 0;
    e_s1 = '0; e_s2 = '0; e_d = '0; e_addr = '0; e_vl = '0;
  endtask

  // One clock cycle. It is entered at a negedge with the inputs already
  // driven. It predicts the issue decision, checks ready, advances the model
  // at the edge and checks every output after the edge.
  task automatic tick();
    int go_alu;
    bit go_ld, go_st, drop, fire, rdy, busy_any;
    #1;
    go_alu = -1; go_ld = 0; go_st = 0; drop = 0;
    if (m_held) begin
      case (h_op)
        0, 1: if (!pending(h_s1) && !pending(h_s2) && !pending(h_d))
                for (int i = 0; i < NA; i++) begin
                  int k;
                  k = (m_rr + i) % NA;
                  if (go_alu < 0 && !m_alu_busy[k]) go_alu = k;
                end
        2: go_ld = !m_mem_busy && !pending(h_d);
        3: go_st = !m_mem_busy && !pending(h_s1);
        default: drop = 1;
      endcase
    end
    fire = (go_alu >= 0) || go_ld || go_st;
    rdy = !m_held || fire || drop;
    m_accept = ins_valid_i && rdy;
    check("ins_ready", {31'b0, ins_ready_o}, {31'b0, rdy});
    @(posedge clk);
    for (int k = 0; k < NA; k++) if (alu_done_i[k]) m_alu_busy[k] = 0;
    if (mem_done_i) m_mem_busy = 0;
    e_alu_valid = '0; e_ml = go_ld; e_ms = go_st; e_err = drop;
    if (go_alu >= 0) begin
      m_alu_busy[go_alu] = 1; m_alu_dst[go_alu] = h_d;
      m_rr = (go_alu + 1) % NA; e_alu_valid[go_alu] = 1'b1;
    end
    if (go_ld || go_st) begin m_mem_busy = 1; m_mem_ld = go_ld; m_mem_dst = h_d; end
    if (fire) begin
      e_sub = (h_op == 1); e_s1 = h_s1; e_s2 = h_s2; e_d = h_d; e_addr = h_addr; e_vl = h_vl;
    end
    if (m_accept) begin
      m_held = 1; h_op = classify(add_i, sub_i, load_i, store_i);
      h_s1 = src1_i; h_s2 = src2_i; h_d = dst_i; h_addr = addr_i; h_vl = vlen_i;
    end else if (fire || drop) begin
      m_held = 0;
    end
    busy_any = m_mem_busy;
    for (int k = 0; k < NA; k++) busy_any |= m_alu_busy[k];
    #1;
    check("alu_valid", 32'(alu_valid_o), 32'(e_alu_valid));
    check("mem_load",  {31'b0, mem_load_o},  {31'b0, e_ml});
    check("mem_store", {31'b0, mem_store_o}, {31'b0, e_ms});
    check("err",       {31'b0, err_o},       {31'b0, e_err});
    check("disp_sub",  {31'b0, disp_sub_o},  {31'b0, e_sub});
    check("disp_src1", 32'(disp_src1_o), 32'(e_s1));
    check("disp_src2", 32'(disp_src2_o), 32'(e_s2));
    check("disp_dst",  32'(disp_dst_o),  32'(e_d));
    check("disp_addr", 32'(disp_addr_o), 32'(e_addr));
    check("disp_vlen", 32'(disp_vlen_o), 32'(e_vl));
    check("idle",      {31'b0, idle_o},  {31'b0, !m_held && !busy_any});
    @(negedge clk);
  endtask

  task automatic send_op(input logic a, input logic s, input logic l, input logic st,
                         input logic [RW-1:0] s1, input logic [RW-1:0] s2,
                         input logic [RW-1:0] d, input logic [AW-1:0] ad,
                         input logic [VW-1:0] vl);
    bit got;
    got = 0;
    add_i = a; sub_i = s; load_i = l; store_i = st;
    src1_i = s1; src2_i = s2; dst_i = d; addr_i = ad; vlen_i = vl;
    ins_valid_i = 1;
    for (int n = 0; n < 50 && !got; n++) begin
      tick();
      if (m_accept) got = 1;
    end
    ins_valid_i = 0;
    check("send_accepted", {31'b0, got}, 32'd1);
  endtask

  task automatic idle_cycles(input int n);
    ins_valid_i = 0;
    repeat (n) tick();
  endtask

  task automatic drain();
    ins_valid_i = 0;
    alu_done_i = '1; mem_done_i = 1;
    repeat (3) tick();
    alu_done_i = '0; mem_done_i = 0;
    tick();
  endtask

  task automatic do_reset();
    rst_ni = 0;
    #1;
    model_reset();
    check("rst_ready",     {31'b0, ins_ready_o}, 32'd1);
    check("rst_idle",      {31'b0, idle_o},      32'd1);
    check("rst_alu_valid", 32'(alu_valid_o),     32'd0);
    check("rst_mem",       {30'b0, mem_load_o, mem_store_o}, 32'd0);
    check("rst_err",       {31'b0, err_o},       32'd0);
    check("rst_disp_dst",  32'(disp_dst_o),      32'd0);
    repeat (2) @(negedge clk);
    rst_ni = 1;
  endtask

  initial begin
    rst_ni = 0; ins_valid_i = 0;
    add_i = 0; sub_i = 0; load_i = 0; store_i = 0;
    src1_i = '0; src2_i = '0; dst_i = '0; addr_i = '0; vlen_i = '0;
    alu_done_i = '0; mem_done_i = 0;
    @(negedge clk);
    do_reset();
    idle_cycles(2);

    // ADD src1=0 src2=1 dst=2 vlen=8: one-cycle pulse on ALU 0 after the next edge.
    send_op(1, 0, 0, 0, 2'd0, 2'd1, 2'd2, 10'h000, 4'd8);
    tick();
    check("add_alu0",  32'(alu_valid_o), 32'd1);
    check("add_dst",   32'(disp_dst_o),  32'd2);
    check("add_vlen",  32'(disp_vlen_o), 32'd8);
    check("add_busy",  {31'b0, idle_o},  32'd0);
    tick();
    check("add_pulse_end", 32'(alu_valid_o), 32'd0);

    // A SUB reading r2 stalls until ALU 0 is done, then issues on the 2nd edge after done.
    send_op(0, 1, 0, 0, 2'd2, 2'd0, 2'd3, 10'h000, 4'd4);
    idle_cycles(3);
    check("sub_stall_ready", {31'b0, ins_ready_o}, 32'd0);
    alu_done_i = 2'b01;
    tick();
    alu_done_i = 2'b00;
    check("sub_not_in_done_cycle", 32'(alu_valid_o), 32'd0);
    tick();
    check("sub_issue_alu1", 32'(alu_valid_o), 32'd2);
    check("sub_flag",       {31'b0, disp_sub_o}, 32'd1);
    drain();

    // Three independent ADDs: the two ALUs take one each, then the third
    // stalls until ALU 1 is done.
    send_op(1, 0, 0, 0, 2'd0, 2'd0, 2'd1, 10'h000, 4'd1);
    send_op(1, 0, 0, 0, 2'd0, 2'd0, 2'd2, 10'h000, 4'd2);
    send_op(1, 0, 0, 0, 2'd0, 2'd0, 2'd3, 10'h000, 4'd3);
    idle_cycles(3);
    check("third_stall_ready", {31'b0, ins_ready_o}, 32'd0);
    alu_done_i = 2'b10;
    tick();
    alu_done_i = 2'b00;
    tick();
    check("third_to_alu1", 32'(alu_valid_o), 32'd2);
    check("third_dst",     32'(disp_dst_o),  32'd3);
    drain();

    // LOAD r3 followed by a STORE of r3: the STORE waits for mem_done.
    send_op(0, 0, 1, 0, 2'd0, 2'd0, 2'd3, 10'h155, 4'd5);
    send_op(0, 0, 0, 1, 2'd3, 2'd0, 2'd0, 10'h2AA, 4'd6);
    idle_cycles(3);
    check("store_stall", {31'b0, mem_store_o}, 32'd0);
    mem_done_i = 1;
    tick();
    mem_done_i = 0;
    tick();
    check("store_issue", {31'b0, mem_store_o}, 32'd1);
    check("store_addr",  32'(disp_addr_o),     32'h2AA);
    drain();

    // Illegal op (add and sub both set): a single err pulse and no dispatch.
    send_op(1, 1, 0, 0, 2'd1, 2'd1, 2'd1, 10'h011, 4'd7);
    tick();
    check("illegal_err",  {31'b0, err_o},    32'd1);
    check("illegal_nodisp", 32'(alu_valid_o), 32'd0);
    tick();
    check("illegal_err_end", {31'b0, err_o}, 32'd0);

    // Reset while an ALU is busy and a dependent op is held; a stray done afterwards is ignored.
    send_op(1, 0, 0, 0, 2'd0, 2'd0, 2'd1, 10'h000, 4'd1);
    send_op(1, 0, 0, 0, 2'd1, 2'd0, 2'd2, 10'h000, 4'd1);
    tick();
    do_reset();
    alu_done_i = '1; mem_done_i = 1;
    tick();
    alu_done_i = '0; mem_done_i = 0;
    tick();
    check("post_reset_idle", {31'b0, idle_o}, 32'd1);

    // Randomized traffic, including stray done pulses and illegal flag combinations.
    for (int c = 0; c < 1500; c++) begin
      int t;
      ins_valid_i = ($urandom_range(0, 9) < 6);
      t = $urandom_range(0, 19);
      add_i = 0; sub_i = 0; load_i = 0; store_i = 0;
      if (t < 18) begin
        case (t % 4)
          0: add_i = 1;
          1: sub_i = 1;
          2: load_i = 1;
          default: store_i = 1;
        endcase
      end else if (t == 19) begin
        add_i = 1; load_i = 1;
      end
      src1_i = RW'($urandom_range(0, 3));
      src2_i = RW'($urandom_range(0, 3));
      dst_i  = RW'($urandom_range(0, 3));
      addr_i = AW'($urandom_range(0, 1023));
      vlen_i = VW'($urandom_range(0, 15));
      for (int k = 0; k < NA; k++) alu_done_i[k] = ($urandom_range(0, 3) == 0);
      mem_done_i = ($urandom_range(0, 3) == 0);
      tick();
    end
    ins_valid_i = 0;
    drain();
    drain();
    check("final_idle", {31'b0, idle_o}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
